// File: rtl/l2_request_queue.sv
// rtl/l2_request_queue.sv - per-core L2 request queue with line-hazard blocking and id-tracked completions
module l2_request_queue #(
    parameter int NUM_ENTRIES   = 8,
    parameter int ADDR_WIDTH    = 26,
    parameter int LINE_BITS     = 512,
    parameter int CORE_ID       = 0,
    parameter int CORE_ID_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [1:0]                       req_op,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_BITS-1:0]             req_data,
    input  logic [LINE_BITS/8-1:0]           req_mask,
    output logic                             l2_req_valid,
    input  logic                             l2_ready,
    output logic [CORE_ID_WIDTH-1:0]         l2_req_core,
    output logic [$clog2(NUM_ENTRIES)-1:0]   l2_req_id,
    output logic [1:0]                       l2_req_op,
    output logic [ADDR_WIDTH-1:0]            l2_req_addr,
    output logic [LINE_BITS-1:0]             l2_req_data,
    output logic [LINE_BITS/8-1:0]           l2_req_mask,
    input  logic                             l2_rsp_valid,
    input  logic [CORE_ID_WIDTH-1:0]         l2_rsp_core,
    input  logic [$clog2(NUM_ENTRIES)-1:0]   l2_rsp_id,
    input  logic                             l2_rsp_status,
    input  logic [LINE_BITS-1:0]             l2_rsp_data,
    output logic                             done_valid,
    output logic [1:0]                       done_op,
    output logic [ADDR_WIDTH-1:0]            done_addr,
    output logic [LINE_BITS-1:0]             done_data,
    output logic                             done_status,
    output logic [$clog2(NUM_ENTRIES):0]     pending_count,
    output logic                             protocol_error
);
    localparam int ID_W   = $clog2(NUM_ENTRIES);
    localparam int MASK_W = LINE_BITS / 8;

    typedef enum logic [1:0] {ST_FREE, ST_SEND, ST_WAIT} entry_state_t;

    entry_state_t            state    [NUM_ENTRIES];
    logic [1:0]              ent_op   [NUM_ENTRIES];
    logic [ADDR_WIDTH-1:0]   ent_addr [NUM_ENTRIES];
    logic [LINE_BITS-1:0]    ent_data [NUM_ENTRIES];
    logic [MASK_W-1:0]       ent_mask [NUM_ENTRIES];

    logic [ID_W-1:0] last_issued;
    logic [ID_W-1:0] alloc_idx;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] scan_idx;
    logic            any_free;
    logic            hazard;
    logic            pick_valid;
    logic            accept;
    logic            handshake;
    logic            rsp_hit;
    logic            rsp_match;
    logic            can_load;
    logic            bypass;

    assign l2_req_core = CORE_ID_WIDTH'(CORE_ID);

    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        hazard    = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (state[i] == ST_FREE) begin
                any_free  = 1'b1;
                alloc_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (state[i] != ST_FREE && ent_addr[i] == req_addr) begin
                hazard = 1'b1;
            end
        end
    end

    assign req_ready = !reset && any_free && !hazard;
    assign accept    = req_valid && req_ready;
    assign handshake = l2_req_valid && l2_ready;
    assign can_load  = !l2_req_valid || l2_ready;
    assign rsp_hit   = l2_rsp_valid && (l2_rsp_core == CORE_ID_WIDTH'(CORE_ID));
    assign rsp_match = rsp_hit && (state[l2_rsp_id] == ST_WAIT);

    // Round-robin scan from last_issued+1; the entry leaving via handshake is skipped and the
    // entry being allocated this cycle is eligible so an idle queue issues on the next cycle.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 1; k <= NUM_ENTRIES; k++) begin
            scan_idx = last_issued + ID_W'(k);
            if (!pick_valid &&
                ((state[scan_idx] == ST_SEND && !(handshake && scan_idx == l2_req_id)) ||
                 (accept && scan_idx == alloc_idx))) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign bypass = accept && (pick_idx == alloc_idx);

    always_ff @(posedge clk) begin
        if (accept) begin
            ent_op[alloc_idx]   <= req_op;
            ent_addr[alloc_idx] <= req_addr;
            ent_data[alloc_idx] <= req_data;
            ent_mask[alloc_idx] <= req_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state[i] <= ST_FREE;
            end
            last_issued    <= '1;
            l2_req_valid   <= 1'b0;
            l2_req_id      <= '0;
            l2_req_op      <= '0;
            l2_req_addr    <= '0;
            l2_req_data    <= '0;
            l2_req_mask    <= '0;
            done_valid     <= 1'b0;
            done_op        <= '0;
            done_addr      <= '0;
            done_data      <= '0;
            done_status    <= 1'b0;
            pending_count  <= '0;
            protocol_error <= 1'b0;
        end else begin
            if (handshake) begin
                state[l2_req_id] <= ST_WAIT;
            end
            if (rsp_match) begin
                state[l2_rsp_id] <= ST_FREE;
            end
            if (accept) begin
                state[alloc_idx] <= ST_SEND;
            end

            if (can_load) begin
                l2_req_valid <= pick_valid;
                if (pick_valid) begin
                    l2_req_id   <= pick_idx;
                    last_issued <= pick_idx;
                    l2_req_op   <= bypass ? req_op   : ent_op[pick_idx];
                    l2_req_addr <= bypass ? req_addr : ent_addr[pick_idx];
                    l2_req_data <= bypass ? req_data : ent_data[pick_idx];
                    l2_req_mask <= bypass ? req_mask : ent_mask[pick_idx];
                end
            end

            done_valid <= rsp_match;
            if (rsp_match) begin
                done_op     <= ent_op[l2_rsp_id];
                done_addr   <= ent_addr[l2_rsp_id];
                done_data   <= l2_rsp_data;
                done_status <= l2_rsp_status;
            end

            if (rsp_hit && state[l2_rsp_id] != ST_WAIT) begin
                protocol_error <= 1'b1;
            end

            pending_count <= pending_count + (ID_W+1)'(accept) - (ID_W+1)'(rsp_match);
        end
    end
endmodule

// File: tb/tb_l2_request_queue.sv
// tb/tb_l2_request_queue.sv - directed bench with per-cycle scoreboard model for l2_request_queue
module tb_l2_request_queue;
    localparam int N  = 8;
    localparam int AW = 26;
    localparam int LB = 512;
    localparam int MW = LB / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic [LB-1:0] req_data = '0;
    logic [MW-1:0] req_mask = '0;
    logic          l2_req_valid;
    logic          l2_ready = 1'b0;
    logic [1:0]    l2_req_core;
    logic [2:0]    l2_req_id;
    logic [1:0]    l2_req_op;
    logic [AW-1:0] l2_req_addr;
    logic [LB-1:0] l2_req_data;
    logic [MW-1:0] l2_req_mask;
    logic          l2_rsp_valid = 1'b0;
    logic [1:0]    l2_rsp_core = '0;
    logic [2:0]    l2_rsp_id = '0;
    logic          l2_rsp_status = 1'b0;
    logic [LB-1:0] l2_rsp_data = '0;
    logic          done_valid;
    logic [1:0]    done_op;
    logic [AW-1:0] done_addr;
    logic [LB-1:0] done_data;
    logic          done_status;
    logic [3:0]    pending_count;
    logic          protocol_error;

    int n_vec = 0;
    int n_err = 0;

    l2_request_queue #(
        .NUM_ENTRIES(N), .ADDR_WIDTH(AW), .LINE_BITS(LB), .CORE_ID(0), .CORE_ID_WIDTH(2)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_data(req_data), .req_mask(req_mask),
        .l2_req_valid(l2_req_valid), .l2_ready(l2_ready), .l2_req_core(l2_req_core),
        .l2_req_id(l2_req_id), .l2_req_op(l2_req_op), .l2_req_addr(l2_req_addr),
        .l2_req_data(l2_req_data), .l2_req_mask(l2_req_mask),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_core(l2_rsp_core), .l2_rsp_id(l2_rsp_id),
        .l2_rsp_status(l2_rsp_status), .l2_rsp_data(l2_rsp_data),
        .done_valid(done_valid), .done_op(done_op), .done_addr(done_addr),
        .done_data(done_data), .done_status(done_status),
        .pending_count(pending_count), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] v;
        for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Scoreboard: each slot is free, accepted-not-issued, or issued-awaiting-response.
    logic          m_busy [N];
    logic          m_iss  [N];
    logic [1:0]    m_op   [N];
    logic [AW-1:0] m_addr [N];
    logic [LB-1:0] m_data [N];
    logic [MW-1:0] m_mask [N];
    logic          m_perr;
    logic          ed_v;
    logic [1:0]    ed_op;
    logic [AW-1:0] ed_addr;
    logic [LB-1:0] ed_data;
    logic          ed_status;
    logic          prev_stall;
    logic [2:0]    prev_id;
    logic [AW-1:0] prev_addr;

    always @(negedge clk) begin
        int cnt;
        int slot;
        logic hit;
        logic exp_rdy;
        if (reset) begin
            chk("rst_l2_req_valid", l2_req_valid, 0);
            chk("rst_done_valid", done_valid, 0);
            chk("rst_pending", pending_count, 0);
            chk("rst_perr", protocol_error, 0);
            chk("rst_req_ready", req_ready, 0);
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0;
                m_iss[i]  = 0;
            end
            m_perr = 0;
            ed_v = 0;
            prev_stall = 0;
        end else begin
            cnt = 0;
            hit = 0;
            slot = -1;
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) begin
                    cnt++;
                    if (m_addr[i] == req_addr) hit = 1;
                end else if (slot < 0) begin
                    slot = i;
                end
            end
            exp_rdy = (cnt < N) && !hit;
            chk("req_ready", req_ready, exp_rdy);
            chk("pending_count", pending_count, cnt);
            chk("protocol_error", protocol_error, m_perr);
            chk("done_valid", done_valid, ed_v);
            if (ed_v) begin
                chk("done_op", done_op, ed_op);
                chk("done_addr", done_addr, ed_addr);
                chk("done_data", done_data, ed_data);
                chk("done_status", done_status, ed_status);
            end
            chk("l2_req_core", l2_req_core, 0);
            if (prev_stall) begin
                chk("hold_valid", l2_req_valid, 1);
                chk("hold_id", l2_req_id, prev_id);
                chk("hold_addr", l2_req_addr, prev_addr);
            end
            if (l2_req_valid) begin
                chk("issue_pending", m_busy[l2_req_id] && !m_iss[l2_req_id], 1);
                chk("issue_op", l2_req_op, m_op[l2_req_id]);
                chk("issue_addr", l2_req_addr, m_addr[l2_req_id]);
                chk("issue_data", l2_req_data, m_data[l2_req_id]);
                chk("issue_mask", l2_req_mask, m_mask[l2_req_id]);
            end
            ed_v = 0;
            if (l2_rsp_valid && l2_rsp_core == 2'd0) begin
                if (m_busy[l2_rsp_id] && m_iss[l2_rsp_id]) begin
                    ed_v      = 1;
                    ed_op     = m_op[l2_rsp_id];
                    ed_addr   = m_addr[l2_rsp_id];
                    ed_data   = l2_rsp_data;
                    ed_status = l2_rsp_status;
                    m_busy[l2_rsp_id] = 0;
                    m_iss[l2_rsp_id]  = 0;
                end else begin
                    m_perr = 1;
                end
            end
            if (l2_req_valid && l2_ready) m_iss[l2_req_id] = 1;
            prev_stall = l2_req_valid && !l2_ready;
            prev_id    = l2_req_id;
            prev_addr  = l2_req_addr;
            if (req_valid && exp_rdy && slot >= 0) begin
                m_busy[slot] = 1;
                m_iss[slot]  = 0;
                m_op[slot]   = req_op;
                m_addr[slot] = req_addr;
                m_data[slot] = req_data;
                m_mask[slot] = req_mask;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [AW-1:0] a, input logic [1:0] op);
        req_valid = 1;
        req_addr  = a;
        req_op    = op;
        req_data  = rand_line();
        req_mask  = {$urandom, $urandom};
    endtask

    task automatic respond(input logic [1:0] core, input logic [2:0] id, input logic [LB-1:0] d);
        l2_rsp_valid  = 1;
        l2_rsp_core   = core;
        l2_rsp_id     = id;
        l2_rsp_data   = d;
        l2_rsp_status = 1'($urandom);
    endtask

    task automatic drain();
        req_valid = 0;
        l2_ready  = 1;
        repeat (12) step();
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && m_iss[i]) begin
                respond(2'd0, 3'(i), rand_line());
                step();
            end
        end
        l2_rsp_valid = 0;
        step();
        step();
        chk("drain_empty", pending_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] got [N];
        int n_got;
        logic [LB-1:0] pat_a5;
        pat_a5 = {64{8'hA5}};

        step();
        step();
        chk("reset_pending", pending_count, 0);
        chk("reset_core", l2_req_core, 0);
        reset = 0;
        step();

        // single load, L2 ready immediately
        l2_ready = 1;
        set_req(26'h0000123, 2'd0);
        chk("t1_ready", req_ready, 1);
        step();
        req_valid = 0;
        chk("t1_issue_valid", l2_req_valid, 1);
        chk("t1_issue_id", l2_req_id, 0);
        chk("t1_issue_addr", l2_req_addr, 26'h0000123);
        step();
        respond(2'd0, 3'd0, pat_a5);
        step();
        l2_rsp_valid = 0;
        chk("t1_done_valid", done_valid, 1);
        chk("t1_done_data", done_data, pat_a5);
        step();
        chk("t1_done_pulse", done_valid, 0);
        chk("t1_pending", pending_count, 0);

        // fill all slots with L2 stalled
        l2_ready = 0;
        for (int i = 0; i < N; i++) begin
            set_req(26'h1000 + AW'(i), 2'(i));
            step();
        end
        set_req(26'h2000, 2'd1);
        chk("t2_full_ready", req_ready, 0);
        chk("t2_full_pending", pending_count, 8);
        for (int c = 0; c < 3; c++) begin
            chk("t2_stall_id", l2_req_id, 0);
            step();
        end
        req_valid = 0;
        l2_ready = 1;
        n_got = 0;
        for (int c = 0; c < 30 && n_got < N; c++) begin
            if (l2_req_valid) begin
                got[n_got] = l2_req_id;
                n_got++;
            end
            step();
        end
        l2_ready = 0;
        chk("t2_issue_count", n_got, 8);
        for (int k = 0; k < N; k++) chk("t2_rr_order", got[k], k);
        set_req(26'h2000, 2'd1);
        respond(2'd0, 3'd3, rand_line());
        chk("t2_ready_same_cycle", req_ready, 0);
        step();
        l2_rsp_valid = 0;
        chk("t2_ready_reopen", req_ready, 1);
        step();
        req_valid = 0;
        chk("t2_realloc_id", l2_req_id, 3);
        drain();

        // line hazard on 0x40
        set_req(26'h40, 2'd1);
        step();
        req_valid = 0;
        step();
        set_req(26'h40, 2'd0);
        chk("t3_hazard_block", req_ready, 0);
        step();
        chk("t3_hazard_block2", req_ready, 0);
        respond(2'd0, 3'd0, rand_line());
        chk("t3_hazard_resp_cycle", req_ready, 0);
        step();
        l2_rsp_valid = 0;
        chk("t3_hazard_release", req_ready, 1);
        step();
        req_valid = 0;
        chk("t3_realloc_valid", l2_req_valid, 1);
        chk("t3_realloc_id", l2_req_id, 0);
        step();
        l2_ready = 0;

        // response for another core is ignored
        respond(2'd1, 3'd0, rand_line());
        step();
        l2_rsp_valid = 0;
        chk("t4_no_done", done_valid, 0);
        chk("t4_no_perr", protocol_error, 0);
        chk("t4_pending", pending_count, 1);
        drain();

        // accept, issue and response in one cycle
        set_req(26'h500, 2'd0);
        step();
        req_valid = 0;
        step();
        l2_ready = 0;
        set_req(26'h501, 2'd1);
        step();
        req_valid = 0;
        chk("t6_present_id", l2_req_id, 1);
        set_req(26'h502, 2'd2);
        l2_ready = 1;
        respond(2'd0, 3'd0, rand_line());
        step();
        req_valid = 0;
        l2_rsp_valid = 0;
        l2_ready = 0;
        chk("t6_pending", pending_count, 2);
        chk("t6_done_valid", done_valid, 1);
        chk("t6_done_addr", done_addr, 26'h500);
        chk("t6_next_valid", l2_req_valid, 1);
        chk("t6_next_id", l2_req_id, 2);
        step();
        chk("t6_done_pulse", done_valid, 0);
        drain();

        // response to a free entry, then reset while stalled
        respond(2'd0, 3'd5, rand_line());
        step();
        l2_rsp_valid = 0;
        chk("t5_perr_set", protocol_error, 1);
        step();
        step();
        chk("t5_perr_sticky", protocol_error, 1);
        chk("t5_no_done", done_valid, 0);
        l2_ready = 0;
        set_req(26'h700, 2'd3);
        step();
        req_valid = 0;
        step();
        chk("t5_stalled", l2_req_valid, 1);
        #2;
        reset = 1;
        #1;
        chk("t5_rst_valid", l2_req_valid, 0);
        chk("t5_rst_pending", pending_count, 0);
        chk("t5_rst_perr", protocol_error, 0);
        chk("t5_rst_id", l2_req_id, 0);
        chk("t5_rst_addr", l2_req_addr, 0);
        chk("t5_rst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        reset = 0;
        step();
        chk("t5_post_perr", protocol_error, 0);
        chk("t5_post_ready", req_ready, 1);
        chk("t5_post_valid", l2_req_valid, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
